// File: rtl/xc_pmul_pkg.sv
// Shared definitions for the packed-multiply unit.
// Pack-width codes, FSM state encoding, and lane geometry helpers.
// Contents: PW_* codes, state_t, lane_width(), carry_kill_mask().
package xc_pmul_pkg;

    // Accumulator width: every lane keeps a 2W-bit product, so the lanes fill 64 bits.
    localparam int ACC_W = 64;

    localparam logic [1:0] PW_32 = 2'b00;
    localparam logic [1:0] PW_16 = 2'b01;
    localparam logic [1:0] PW_8  = 2'b10;
    localparam logic [1:0] PW_4  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Lane width W in bits for a pack-width code.
    function automatic logic [5:0] lane_width(input logic [1:0] pw);
        case (pw)
            PW_32:   lane_width = 6'd32;
            PW_16:   lane_width = 6'd16;
            PW_8:    lane_width = 6'd8;
            default: lane_width = 6'd4;
        endcase
    endfunction

    // One bit set at the top of each 2W-bit accumulator lane.
    function automatic logic [ACC_W-1:0] carry_kill_mask(input logic [1:0] pw);
        case (pw)
            PW_32:   carry_kill_mask = 64'h8000_0000_0000_0000;
            PW_16:   carry_kill_mask = 64'h8000_0000_8000_0000;
            PW_8:    carry_kill_mask = 64'h8000_8000_8000_8000;
            default: carry_kill_mask = 64'h8080_8080_8080_8080;
        endcase
    endfunction

endpackage

// File: rtl/xc_pmul_if.sv
// Request/response bundle between the execute stage and the packed multiplier.
// master: execute stage drives valid/flush/op_hi/pw/rs1/rs2/next_ready.
// slave: the unit returns ready/result (result is only nonzero while ready).
interface xc_pmul_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            flush;
    logic            op_hi;
    logic [1:0]      pw;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            next_ready;
    logic            ready;
    logic [XLEN-1:0] result;

    modport master (
        output valid, flush, op_hi, pw, rs1, rs2, next_ready,
        input  ready, result
    );

    modport slave (
        input  valid, flush, op_hi, pw, rs1, rs2, next_ready,
        output ready, result
    );
endinterface

// File: rtl/xc_pmul_lane_add.sv
// Segmented 64-bit adder: independent adds in each lane delimited by kill.
// Latency: purely combinational.
// Ports: a, b addends; kill marks each lane's top bit; sum is the lane-wise sum.
module xc_pmul_lane_add
    import xc_pmul_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic [ACC_W-1:0] kill,
    output logic [ACC_W-1:0] sum
);
    logic [ACC_W-1:0] raw;

    // With each lane's top bit cleared in both operands, the carry into that
    // bit lands there and cannot ripple onward; the top bit is then fixed up
    // by xoring the operands' own top bits back in.
    assign raw = (a & ~kill) + (b & ~kill);
    assign sum = raw ^ ((a ^ b) & kill);

endmodule

// File: rtl/xc_pmul_unit.sv
// Iterative packed multiplier for xc.pmul.l / xc.pmul.h (one rs2 bit per lane per cycle).
// Latency: ready in the cycle after edge N+W when valid is first sampled at edge N.
// Backpressure: holds DONE with a stable result until next_ready; flush or dropped valid aborts.
module xc_pmul_unit
    import xc_pmul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       g_clk,
    input  logic       g_rst,
    xc_pmul_if.slave   bus
);
    state_t            state_q, state_d;
    logic [XLEN-1:0]   rs1_q, rs2_q;
    logic [1:0]        pw_q;
    logic              op_hi_q;
    logic [4:0]        cnt_q;
    logic [ACC_W-1:0]  acc_q, pp, acc_sum;
    logic              last_bit;
    logic              accept;
    logic              step;
    logic [XLEN-1:0]   res;

    assign last_bit = ({1'b0, cnt_q} == (lane_width(pw_q) - 6'd1));
    assign accept   = (state_q == ST_IDLE) && bus.valid && !bus.flush;
    assign step     = (state_q == ST_BUSY) && bus.valid && !bus.flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.valid && !bus.flush) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.flush || !bus.valid) state_d = ST_IDLE;
                else if (last_bit)           state_d = ST_DONE;
            end
            ST_DONE: if (bus.flush || !bus.valid || bus.next_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Partial product for the current multiplier bit, placed in each 2W-bit lane.
    always_comb begin
        pp = '0;
        case (pw_q)
            PW_32: if (rs2_q[cnt_q]) pp = {32'd0, rs1_q} << cnt_q;
            PW_16: for (int k = 0; k < 2; k++)
                if (rs2_q[k*16 + int'(cnt_q[3:0])])
                    pp[k*32 +: 32] = {16'd0, rs1_q[k*16 +: 16]} << cnt_q[3:0];
            PW_8: for (int k = 0; k < 4; k++)
                if (rs2_q[k*8 + int'(cnt_q[2:0])])
                    pp[k*16 +: 16] = {8'd0, rs1_q[k*8 +: 8]} << cnt_q[2:0];
            default: for (int k = 0; k < 8; k++)
                if (rs2_q[k*4 + int'(cnt_q[1:0])])
                    pp[k*8 +: 8] = {4'd0, rs1_q[k*4 +: 4]} << cnt_q[1:0];
        endcase
    end

    xc_pmul_lane_add u_add (
        .a    (acc_q),
        .b    (pp),
        .kill (carry_kill_mask(pw_q)),
        .sum  (acc_sum)
    );

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            pw_q    <= PW_32;
            op_hi_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (accept) begin
            rs1_q   <= bus.rs1;
            rs2_q   <= bus.rs2;
            pw_q    <= bus.pw;
            op_hi_q <= bus.op_hi;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_sum;
            cnt_q   <= cnt_q + 5'd1;
        end
    end

    // Pick the low or high W bits of every 2W-bit lane; zero outside DONE.
    always_comb begin
        res = '0;
        if (state_q == ST_DONE) begin
            case (pw_q)
                PW_32: res = op_hi_q ? acc_q[63:32] : acc_q[31:0];
                PW_16: for (int k = 0; k < 2; k++)
                    res[k*16 +: 16] = acc_q[k*32 + (op_hi_q ? 16 : 0) +: 16];
                PW_8: for (int k = 0; k < 4; k++)
                    res[k*8 +: 8] = acc_q[k*16 + (op_hi_q ? 8 : 0) +: 8];
                default: for (int k = 0; k < 8; k++)
                    res[k*4 +: 4] = acc_q[k*8 + (op_hi_q ? 4 : 0) +: 4];
            endcase
        end
    end

    assign bus.ready  = (state_q == ST_DONE);
    assign bus.result = res;

endmodule

// File: tb/tb_xc_pmul_unit.sv
// Directed bench for xc_pmul_unit: fixed vectors, abort paths, stall, random lanes.
// Latency: measured in edges from the first edge that samples valid.
// Backpressure: exercises next_ready low in DONE and the handshake back to IDLE.
module tb_xc_pmul_unit;

    logic g_clk;
    logic g_rst;
    int   checks;
    int   failures;

    xc_pmul_if #(.XLEN(32)) bus ();

    xc_pmul_unit #(.XLEN(32)) dut (
        .g_clk (g_clk),
        .g_rst (g_rst),
        .bus   (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Per-lane unsigned reference product using the native multiplier.
    function automatic logic [31:0] ref_pmul(input logic [1:0] p, input logic hi,
                                             input logic [31:0] a, input logic [31:0] b);
        int          w;
        logic [63:0] m, la, lb, prod, part;
        logic [31:0] r;
        w = (p == 2'b00) ? 32 : (p == 2'b01) ? 16 : (p == 2'b10) ? 8 : 4;
        m = (64'd1 << w) - 64'd1;
        r = '0;
        for (int k = 0; k < 32 / w; k++) begin
            la   = {32'd0, a >> (k * w)} & m;
            lb   = {32'd0, b >> (k * w)} & m;
            prod = la * lb;
            part = (hi ? (prod >> w) : prod) & m;
            part = part << (k * w);
            r    = r | part[31:0];
        end
        return r;
    endfunction

    // Wait for ready, counting edges; gives up after 100 edges.
    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge g_clk); #1;
            lat++;
        end while (!bus.ready && lat < 100);
    endtask

    task automatic do_op(input string tag, input logic [1:0] p, input logic hi,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        bus.valid = 1'b1; bus.flush = 1'b0; bus.pw = p; bus.op_hi = hi;
        bus.rs1 = a; bus.rs2 = b; bus.next_ready = 1'b0;
        wait_ready(lat);
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_latency"}, lat, exp_lat);
        bus.next_ready = 1'b1;
        @(posedge g_clk); #1;
        check({tag, "_ready_after_ack"}, {31'd0, bus.ready}, 32'd0);
        bus.valid = 1'b0; bus.next_ready = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int rises;
        rises = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge g_clk); #1;
            if (bus.ready || bus.result != 32'd0) rises++;
        end
        check(tag, rises, 0);
    endtask

    initial begin
        int          lat;
        logic [1:0]  rp;
        logic        rh;
        logic [31:0] ra, rb;

        checks = 0; failures = 0;
        g_rst = 1'b1;
        bus.valid = 1'b0; bus.flush = 1'b0; bus.op_hi = 1'b0; bus.pw = 2'b00;
        bus.rs1 = '0; bus.rs2 = '0; bus.next_ready = 1'b0;
        @(posedge g_clk); @(posedge g_clk); #1;
        check("reset_ready", {31'd0, bus.ready}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        g_rst = 1'b0;

        do_op("pw32_hi", 2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33);
        do_op("pw32_lo", 2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
        do_op("pw16_lo", 2'b01, 1'b0, 32'hFFFF_0003, 32'hFFFF_0005, 32'h0001_000F, 17);
        do_op("pw16_hi", 2'b01, 1'b1, 32'hFFFF_0003, 32'hFFFF_0005, 32'hFFFE_0000, 17);
        do_op("pw8_lo",  2'b10, 1'b0, 32'h8040_2010, 32'h0202_0202, 32'h0080_4020, 9);
        do_op("pw8_hi",  2'b10, 1'b1, 32'h8040_2010, 32'h0202_0202, 32'h0100_0000, 9);
        do_op("pw4_lo",  2'b11, 1'b0, 32'hFFFF_FFFF, 32'h2222_2222, 32'hEEEE_EEEE, 5);
        do_op("pw4_hi",  2'b11, 1'b1, 32'hFFFF_FFFF, 32'h2222_2222, 32'h1111_1111, 5);
        do_op("pw32_full", 2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

        // Flush after ten BUSY cycles: no result may ever appear.
        bus.valid = 1'b1; bus.pw = 2'b00; bus.op_hi = 1'b0;
        bus.rs1 = 32'd7; bus.rs2 = 32'd9;
        repeat (11) @(posedge g_clk);
        #1 bus.flush = 1'b1;
        @(posedge g_clk); #1;
        bus.flush = 1'b0; bus.valid = 1'b0;
        expect_quiet("flush_quiet", 40);
        do_op("after_flush", 2'b00, 1'b0, 32'd3, 32'd5, 32'h0000_000F, 33);

        // Synchronous reset in the middle of an operation.
        bus.valid = 1'b1; bus.pw = 2'b00; bus.rs1 = 32'd11; bus.rs2 = 32'd13;
        repeat (11) @(posedge g_clk);
        #1 g_rst = 1'b1;
        @(posedge g_clk); #1;
        check("midrst_ready", {31'd0, bus.ready}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        g_rst = 1'b0; bus.valid = 1'b0;
        expect_quiet("midrst_quiet", 40);
        do_op("after_rst", 2'b00, 1'b0, 32'd3, 32'd5, 32'h0000_000F, 33);

        // Stall in DONE, then release with valid still high.
        bus.valid = 1'b1; bus.pw = 2'b11; bus.op_hi = 1'b0;
        bus.rs1 = 32'hFFFF_FFFF; bus.rs2 = 32'h2222_2222; bus.next_ready = 1'b0;
        wait_ready(lat);
        check("stall_latency", lat, 5);
        bus.rs1 = 32'h0; bus.rs2 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge g_clk); #1;
            check("stall_ready", {31'd0, bus.ready}, 32'd1);
            check("stall_result", bus.result, 32'hEEEE_EEEE);
        end
        bus.next_ready = 1'b1;
        @(posedge g_clk); #1;
        check("release_ready", {31'd0, bus.ready}, 32'd0);
        check("release_result", bus.result, 32'd0);
        bus.valid = 1'b0; bus.next_ready = 1'b0;
        expect_quiet("no_relaunch", 10);

        // Random operands over every pack width and half.
        for (int i = 0; i < 16; i++) begin
            rp = 2'(i % 4);
            rh = 1'((i / 4) % 2);
            ra = $urandom;
            rb = $urandom;
            do_op("random", rp, rh, ra, rb, ref_pmul(rp, rh, ra, rb),
                  (rp == 2'b00) ? 33 : (rp == 2'b01) ? 17 : (rp == 2'b10) ? 9 : 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xc_pmul_unit.md
Name: xc_pmul_unit

Overview:
- Multi-cycle packed-multiply functional unit in the scarv-cpu execute stage. It implements xc.pmul.l and xc.pmul.h.
- Each lane of rs1 is multiplied by the corresponding lane of rs2, with a selectable pack width. The unit returns either the low or the high half of every lane product.
- It is the RTL end checked against the packed-arithmetic RVFI instruction models. The result must be bit-identical to the per-lane low/high product.
- Iterative shift-add: one multiplier bit per lane per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_rst  in  1  synchronous reset, active-high.
- valid  in  1  operation request. Held high with stable operands until the result is consumed, or until flush.
- flush  in  1  kill the in-flight operation.
- op_hi  in  1  0 = xc.pmul.l (low halves), 1 = xc.pmul.h (high halves).
- pw  in  2  pack width: 00 = 32-bit lanes, 01 = 16, 10 = 8, 11 = 4.
- rs1  in  32  multiplicand lanes.
- rs2  in  32  multiplier lanes.
- next_ready  in  1  downstream accepts the result this cycle.
- ready  out  1  result valid.
- result  out  32  packed result.

Behaviour:
- Reset (g_rst=1 at the edge): state=IDLE, count=0, accumulator=0, ready=0, result=0. Reset overrides every other input.
- Lane width W = 32/16/8/4 from pw; lane count L = 32/W.
- Each lane has a 2W-bit accumulator; the concatenated accumulators total 64 bits.
- Carries never cross lane boundaries.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - valid=1 and flush=0: latch rs1, rs2, pw, op_hi; clear accumulator; count=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - For every lane k: if bit `count` of rs2 lane k is 1, add (zero-extended rs1 lane k) << count into acc lane k, modulo 2^(2W).
  - count increments.
  - When count==W-1 is processed, go to DONE.
- DONE:
  - ready=1.
  - result = concatenation over lanes of acc lane k bits [W-1:0] if op_hi=0, else bits [2W-1:W]. Lane 0 occupies the least significant bits.
  - If next_ready=1, go to IDLE; otherwise hold DONE with result stable.
- Latency: valid first sampled at edge N → ready high in the cycle after edge N+W. That is 33 cycles for pw=00 and 5 cycles for pw=11.
- ready=0 and result=0 outside DONE.
- flush=1 in any state → IDLE at the next edge; no result is produced. flush beats next_ready.
- valid=0 while in BUSY or DONE is treated as an abort (instruction killed) → IDLE.
- In DONE with next_ready=1, the unit goes to IDLE even if valid stays high. A new operation is accepted only from IDLE, so a stalled instruction is never re-executed.
- Inputs are latched at accept; later operand changes are ignored.
- Products are unsigned. Each lane wraps independently: 32-bit lanes use the full 64-bit product.

Decomposition:
- Shared package xc_pmul_pkg:
  - pw encoding constants (PW_32, PW_16, PW_8, PW_4).
  - FSM state enum.
  - lane-width function (pw → W).
  - carry-kill mask function (pw → 64-bit mask of lane top bits).
- Sub-module xc_pmul_lane_add: 64-bit adder segmented by the carry-kill mask. It performs the per-lane partial-product addition and is purely combinational.

Test Plan:
- pw=00, op_hi=1, rs1=0x00010000, rs2=0x00010000 → ready after 33 cycles, result=0x00000001. With op_hi=0 → 0x00000000.
- pw=01, rs1=0xFFFF0003, rs2=0xFFFF0005 → op_hi=0: 0x0001000F; op_hi=1: 0xFFFE0000; ready after 17 cycles.
- pw=10, rs1=0x80402010, rs2=0x02020202 → op_hi=0: 0x00804020; op_hi=1: 0x01000000 (proves no cross-lane carry).
- pw=11, rs1=0xFFFFFFFF, rs2=0x22222222 → op_hi=0: 0xEEEEEEEE; op_hi=1: 0x11111111; ready after 5 cycles.
- Launch pw=00, assert flush at BUSY cycle 10 → IDLE next edge, ready never rises. Reissue 3×5 → 0x0000000F. Repeat using g_rst mid-operation → all outputs 0.
- DONE with next_ready=0 for 4 cycles → ready and result held stable. Then next_ready=1 with valid still high → IDLE, no second launch. Random compare against the per-lane reference product for all pw/op_hi.
